// File: rtl/park_seq_ctrl.sv
// Resource-shared Park transform: one sin/cos request and four products through a
// single 16x16 multiplier, with a one-deep pending slot for samples that arrive while busy.
module park_seq_ctrl (
  input  logic               rstn,
  input  logic               clk,
  input  logic               i_en,
  input  logic        [11:0] psi,
  input  logic signed [15:0] i_ialpha,
  input  logic signed [15:0] i_ibeta,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               sc_en,
  output logic        [11:0] sc_theta,
  input  logic               sc_oen,
  input  logic signed [15:0] sc_sin,
  input  logic signed [15:0] sc_cos,
  output logic               o_en,
  output logic signed [15:0] o_id,
  output logic signed [15:0] o_iq
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_SC = 3'd1;
  localparam logic [2:0] MUL0    = 3'd2;
  localparam logic [2:0] MUL1    = 3'd3;
  localparam logic [2:0] MUL2    = 3'd4;
  localparam logic [2:0] MUL3    = 3'd5;

  logic        [2:0]  state;
  logic signed [15:0] alpha_r, beta_r, sin_r, cos_r;
  logic signed [31:0] acc, idacc;
  logic               pend_v;
  logic signed [15:0] pend_alpha, pend_beta;
  logic        [11:0] pend_psi;

  logic               launch, from_pend, pend_wr, overrun;
  logic signed [15:0] src_alpha, src_beta;
  logic        [11:0] src_psi;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod, iq_full;
  logic               unused_low;

  // sincos handshake: sc_en is a one-cycle request carrying sc_theta (held until the
  // next request); the result is taken on the first cycle sc_oen is high in WAIT_SC.
  assign launch    = ((state == IDLE) && i_en) || ((state == MUL3) && (pend_v || i_en));
  assign from_pend = launch && pend_v;
  assign pend_wr   = i_en && (state != IDLE) && !(launch && !pend_v);
  assign overrun   = pend_wr && pend_v && !from_pend;

  assign src_alpha = pend_v ? pend_alpha : i_ialpha;
  assign src_beta  = pend_v ? pend_beta  : i_ibeta;
  assign src_psi   = pend_v ? pend_psi   : psi;

  always_comb begin
    mul_a = alpha_r;
    mul_b = cos_r;
    case (state)
      MUL0:    begin mul_a = alpha_r; mul_b = cos_r; end
      MUL1:    begin mul_a = beta_r;  mul_b = sin_r; end
      MUL2:    begin mul_a = beta_r;  mul_b = cos_r; end
      MUL3:    begin mul_a = alpha_r; mul_b = sin_r; end
      default: begin mul_a = alpha_r; mul_b = cos_r; end
    endcase
  end

  assign prod       = 32'(mul_a * mul_b);
  assign iq_full    = acc - prod;
  assign unused_low = ^{idacc[15:0], iq_full[15:0]};
  assign o_busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      alpha_r    <= '0;
      beta_r     <= '0;
      sin_r      <= '0;
      cos_r      <= '0;
      acc        <= '0;
      idacc      <= '0;
      pend_v     <= 1'b0;
      pend_alpha <= '0;
      pend_beta  <= '0;
      pend_psi   <= '0;
      sc_en      <= 1'b0;
      sc_theta   <= '0;
      o_en       <= 1'b0;
      o_overrun  <= 1'b0;
      o_id       <= '0;
      o_iq       <= '0;
    end else begin
      sc_en     <= launch;
      o_en      <= 1'b0;
      o_overrun <= overrun;

      if (launch) begin
        alpha_r  <= src_alpha;
        beta_r   <= src_beta;
        sc_theta <= src_psi;
      end

      // A write takes priority so a MUL3 swap keeps the slot full with the new sample.
      if (pend_wr) begin
        pend_v     <= 1'b1;
        pend_alpha <= i_ialpha;
        pend_beta  <= i_ibeta;
        pend_psi   <= psi;
      end else if (from_pend) begin
        pend_v <= 1'b0;
      end

      case (state)
        IDLE: if (launch) state <= WAIT_SC;
        WAIT_SC: begin
          if (sc_oen) begin
            sin_r <= sc_sin;
            cos_r <= sc_cos;
            state <= MUL0;
          end
        end
        MUL0: begin
          acc   <= prod;
          state <= MUL1;
        end
        MUL1: begin
          idacc <= acc + prod;
          state <= MUL2;
        end
        MUL2: begin
          acc   <= prod;
          state <= MUL3;
        end
        MUL3: begin
          o_id  <= idacc[31:16];
          o_iq  <= iq_full[31:16];
          o_en  <= 1'b1;
          state <= launch ? WAIT_SC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_park_seq_ctrl.sv
// Directed bench for park_seq_ctrl: drives the sincos side by hand and checks results,
// latency, reset abort, floor rounding, wrap and pending-slot overrun behaviour.
module tb_park_seq_ctrl;

  logic               rstn;
  logic               clk;
  logic               i_en;
  logic        [11:0] psi;
  logic signed [15:0] i_ialpha, i_ibeta;
  logic               o_busy, o_overrun, sc_en;
  logic        [11:0] sc_theta;
  logic               sc_oen;
  logic signed [15:0] sc_sin, sc_cos;
  logic               o_en;
  logic signed [15:0] o_id, o_iq;

  int n_checks = 0;
  int n_fail   = 0;

  park_seq_ctrl dut (
    .rstn(rstn), .clk(clk), .i_en(i_en), .psi(psi),
    .i_ialpha(i_ialpha), .i_ibeta(i_ibeta),
    .o_busy(o_busy), .o_overrun(o_overrun),
    .sc_en(sc_en), .sc_theta(sc_theta),
    .sc_oen(sc_oen), .sc_sin(sc_sin), .sc_cos(sc_cos),
    .o_en(o_en), .o_id(o_id), .o_iq(o_iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while WAIT_SC; returns at the negedge of the o_en cycle.
  task automatic give_sc(input logic signed [15:0] s, input logic signed [15:0] c,
                         output int lat);
    sc_oen = 1'b1;
    sc_sin = s;
    sc_cos = c;
    @(negedge clk);
    sc_oen = 1'b0;
    lat = 1;
    while (o_en !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_sample(input string tag,
                            input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic [11:0] p,
                            input logic signed [15:0] s, input logic signed [15:0] c,
                            input logic signed [15:0] eid, input logic signed [15:0] eiq);
    int lat;
    i_en = 1'b1; i_ialpha = a; i_ibeta = b; psi = p;
    @(negedge clk);
    i_en = 1'b0;
    check({tag, "_sc_en"}, 32'(sc_en), 1);
    check({tag, "_theta"}, 32'(sc_theta), 32'(p));
    give_sc(s, c, lat);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_id"}, o_id, eid);
    check({tag, "_iq"}, o_iq, eiq);
    check({tag, "_busy"}, 32'(o_busy), 0);
    @(negedge clk);
    check({tag, "_en_drop"}, 32'(o_en), 0);
    check({tag, "_id_hold"}, o_id, eid);
  endtask

  initial begin
    int lat;
    int seen;
    rstn = 1'b0; i_en = 1'b0; psi = '0; i_ialpha = '0; i_ibeta = '0;
    sc_oen = 1'b0; sc_sin = '0; sc_cos = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_en", 32'(o_en), 0);
    check("rst_sc_en", 32'(sc_en), 0);
    check("rst_theta", 32'(sc_theta), 0);
    check("rst_id", o_id, 0);
    check("rst_iq", o_iq, 0);
    check("rst_ovr", 32'(o_overrun), 0);
    rstn = 1'b1;
    @(negedge clk);

    run_sample("unit", 16'sd16384, 16'sd0, 12'h123, 16'sd0, 16'sd16384, 16'sd4096, 16'sd0);

    // Abort during MUL1: sc_oen in cycle t, MUL0 at t+1, MUL1 at t+2.
    i_en = 1'b1; i_ialpha = 16'sd1000; i_ibeta = -16'sd2000; psi = 12'h321;
    @(negedge clk);
    i_en = 1'b0;
    sc_oen = 1'b1; sc_sin = 16'sd16384; sc_cos = 16'sd0;
    @(negedge clk);
    sc_oen = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_id", o_id, 0);
    check("abort_iq", o_iq, 0);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_theta", 32'(sc_theta), 0);
    check("abort_sc_en", 32'(sc_en), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_en === 1'b1 || o_busy === 1'b1) seen++;
    end
    check("abort_no_en", seen, 0);

    run_sample("rot", 16'sd1000, -16'sd2000, 12'h456, 16'sd16384, 16'sd0, -16'sd500, -16'sd250);
    run_sample("floor", -16'sd1, 16'sd0, 12'hABC, 16'sd0, 16'sd16384, -16'sd1, 16'sd0);
    run_sample("wrap", -16'sd32768, -16'sd32768, 12'hFFF, -16'sd32768, -16'sd32768,
               -16'sd32768, 16'sd0);

    // Overrun: A launches, B fills the slot, C overwrites B.
    i_en = 1'b1; i_ialpha = 16'sd16384; i_ibeta = 16'sd0; psi = 12'h111;
    @(negedge clk);
    i_ialpha = 16'sd7; i_ibeta = 16'sd7; psi = 12'h222;
    @(negedge clk);
    check("ovr_b_quiet", 32'(o_overrun), 0);
    i_ialpha = 16'sd1000; i_ibeta = -16'sd2000; psi = 12'h333;
    @(negedge clk);
    i_en = 1'b0;
    check("ovr_pulse", 32'(o_overrun), 1);
    give_sc(16'sd0, 16'sd16384, lat);
    check("ovr_a_lat", lat, 5);
    check("ovr_a_id", o_id, 4096);
    check("ovr_a_iq", o_iq, 0);
    check("ovr_c_sc_en", 32'(sc_en), 1);
    check("ovr_c_theta", 32'(sc_theta), 32'h333);
    check("ovr_busy", 32'(o_busy), 1);
    give_sc(16'sd16384, 16'sd0, lat);
    check("ovr_c_lat", lat, 5);
    check("ovr_c_id", o_id, -500);
    check("ovr_c_iq", o_iq, -250);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_en === 1'b1 || sc_en === 1'b1 || o_overrun === 1'b1) seen++;
    end
    check("ovr_b_dropped", seen, 0);
    check("ovr_idle", 32'(o_busy), 0);

    // Direct launch from live inputs in the MUL3 cycle with an empty slot.
    i_en = 1'b1; i_ialpha = -16'sd1; i_ibeta = 16'sd0; psi = 12'h0AA;
    @(negedge clk);
    i_en = 1'b0;
    sc_oen = 1'b1; sc_sin = 16'sd0; sc_cos = 16'sd16384;
    @(negedge clk);
    sc_oen = 1'b0;
    repeat (3) @(negedge clk);
    i_en = 1'b1; i_ialpha = 16'sd1000; i_ibeta = -16'sd2000; psi = 12'h0BB;
    @(negedge clk);
    i_en = 1'b0;
    check("m3_en", 32'(o_en), 1);
    check("m3_id", o_id, -1);
    check("m3_sc_en", 32'(sc_en), 1);
    check("m3_theta", 32'(sc_theta), 32'h0BB);
    check("m3_no_ovr", 32'(o_overrun), 0);
    check("m3_busy", 32'(o_busy), 1);
    give_sc(16'sd16384, 16'sd0, lat);
    check("m3_e_lat", lat, 5);
    check("m3_e_id", o_id, -500);
    check("m3_e_iq", o_iq, -250);
    @(negedge clk);
    check("m3_idle", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
